io_request_ctrl: RTL and testbench

IO_REQUEST_CTRL -- requirements
Module: io_request_ctrl

---
 rtl/io_ctrl_pkg.sv | 22 ++
 rtl/io_request_ctrl_if.sv | 30 +++
 rtl/io_debounce.sv | 48 ++++
 rtl/io_request_ctrl.sv | 126 ++++++++++++
 tb/tb_io_request_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared types and constants for the IO request controller: FSM states, data widths and the
// sign-extension rule applied to the user switch value.
package io_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWaitPress,
        StWaitRelease,
        StDone
    } io_state_e;

    localparam int unsigned DataWidth        = 32;
    localparam int unsigned UserWidth        = 18;
    localparam int unsigned SignExtWidth     = 15;
    localparam int unsigned DefaultNumIoRegs = 5;

    function automatic logic [DataWidth-1:0] sign_extend_user(input logic [UserWidth-1:0] v);
        return {{SignExtWidth{v[UserWidth-1]}}, v[UserWidth-2:0]};
    endfunction

endpackage

// File: rtl/io_request_ctrl_if.sv
// CPU/user-facing signal bundle of the IO request controller. The master modport is the
// CPU/board side, the slave modport is the controller.
interface io_request_ctrl_if;
    import io_ctrl_pkg::*;

    logic                 req_in;
    logic                 req_out;
    logic [DataWidth-1:0] endereco;
    logic [DataWidth-1:0] dadosEscrita;
    logic [UserWidth-1:0] dadosExternos;
    logic                 botao;
    logic                 stall;
    logic [DataWidth-1:0] dadosLidos;
    logic                 io_we;
    logic [2:0]           io_addr;
    logic [DataWidth-1:0] io_wdata;
    logic                 aguardando;
    logic                 erro;

    modport master (
        output req_in, req_out, endereco, dadosEscrita, dadosExternos, botao,
        input  stall, dadosLidos, io_we, io_addr, io_wdata, aguardando, erro
    );

    modport slave (
        input  req_in, req_out, endereco, dadosEscrita, dadosExternos, botao,
        output stall, dadosLidos, io_we, io_addr, io_wdata, aguardando, erro
    );

endinterface

// File: rtl/io_debounce.sv
// Two-flop synchronizer for the active-low confirm key plus a saturating run-length counter
// that reports when the requested level has been seen DEBOUNCE_CYCLES times in a row.
module io_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    input  logic active,
    input  logic restart,
    input  logic want_pressed,
    output logic settled
);

    localparam int unsigned           CntWidth = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(DEBOUNCE_CYCLES);
    localparam logic [CntWidth-1:0] CntLast  = CntWidth'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync2_q;
    logic                match;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= botao;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    // The key is active-low: a pressed sample reads 0.
    assign match   = (sync2_q == ~want_pressed);
    assign settled = active && match && (cnt_q >= CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (!active || restart || !match) begin
            cnt_d = '0;
        end else if (cnt_q < CntMax) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

endmodule

// File: rtl/io_request_ctrl.sv
// Serves CPU IN/OUT instructions: OUT becomes a one-cycle IO bank write strobe, IN waits for a
// debounced press/release of the confirm key and captures the sign-extended switch value.
module io_request_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned NUM_IO_REGS     = DefaultNumIoRegs
) (
    input logic              clock,
    input logic              reset,
    io_request_ctrl_if.slave bus
);

    io_state_e            state_q, state_d;
    logic                 settled, waiting, addr_ok;
    logic                 stall, aguardando;
    logic                 io_we_q, io_we_d;
    logic [2:0]           io_addr_q, io_addr_d;
    logic [DataWidth-1:0] io_wdata_q, io_wdata_d;
    logic [DataWidth-1:0] dados_lidos_q, dados_lidos_d;
    logic                 erro_q, erro_d;

    assign waiting = (state_q == StWaitPress) || (state_q == StWaitRelease);
    assign addr_ok = (bus.endereco < NUM_IO_REGS);

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .botao       (bus.botao),
        .active      (waiting),
        .restart     (state_d != state_q),
        .want_pressed(state_q == StWaitPress),
        .settled     (settled)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_out) begin
                    state_d = StWrite;
                end else if (bus.req_in) begin
                    state_d = StWaitPress;
                end
            end
            StWrite: state_d = StIdle;
            StWaitPress: begin
                if (!bus.req_in) begin
                    state_d = StIdle;
                end else if (settled) begin
                    state_d = StWaitRelease;
                end
            end
            // Once the value is captured the release is always awaited, request or not.
            StWaitRelease: begin
                if (settled) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall      = (bus.req_in || bus.req_out) &&
                     ((state_q == StIdle) || (state_q == StWaitPress) ||
                      (state_q == StWaitRelease));
        aguardando = (state_q == StWaitPress);
    end

    always_comb begin
        io_we_d       = 1'b0;
        io_addr_d     = io_addr_q;
        io_wdata_d    = io_wdata_q;
        erro_d        = erro_q;
        dados_lidos_d = dados_lidos_q;
        if (state_q == StIdle && bus.req_out) begin
            if (addr_ok) begin
                io_we_d    = 1'b1;
                io_addr_d  = bus.endereco[2:0];
                io_wdata_d = bus.dadosEscrita;
            end else begin
                erro_d = 1'b1;
            end
        end
        if (state_q == StWaitPress && bus.req_in && settled) begin
            dados_lidos_d = sign_extend_user(bus.dadosExternos);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_we_q       <= 1'b0;
            io_addr_q     <= '0;
            io_wdata_q    <= '0;
            erro_q        <= 1'b0;
            dados_lidos_q <= '0;
        end else begin
            io_we_q       <= io_we_d;
            io_addr_q     <= io_addr_d;
            io_wdata_q    <= io_wdata_d;
            erro_q        <= erro_d;
            dados_lidos_q <= dados_lidos_d;
        end
    end

    assign bus.stall      = stall;
    assign bus.aguardando = aguardando;
    assign bus.io_we      = io_we_q;
    assign bus.io_addr    = io_addr_q;
    assign bus.io_wdata   = io_wdata_q;
    assign bus.erro       = erro_q;
    assign bus.dadosLidos = dados_lidos_q;

endmodule

// File: tb/tb_io_request_ctrl.sv
// Bench for io_request_ctrl: directed scenarios with fixed expectations, then random CPU/key
// traffic compared every cycle against a transaction-level model.
module tb_io_request_ctrl;

    localparam int unsigned Deb   = 4;
    localparam int unsigned NRegs = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    io_request_ctrl_if bus ();

    io_request_ctrl #(
        .DEBOUNCE_CYCLES(Deb),
        .NUM_IO_REGS    (NRegs)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference model: phase 0 idle, 1 write, 2 wait press, 3 wait release, 4 done.
    int          m_phase;
    logic        m_s1, m_s2, m_we, m_erro;
    logic [2:0]  m_addr;
    logic [31:0] m_wdata, m_lidos;
    bit          samples[$];

    function automatic bit held(input bit level);
        if (samples.size() != Deb) return 1'b0;
        foreach (samples[i]) if (samples[i] != level) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_s1 = 1'b1; m_s2 = 1'b1; m_we = 1'b0; m_erro = 1'b0;
        m_addr = '0; m_wdata = '0; m_lidos = '0;
        samples.delete();
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        int nxt;
        nxt  = m_phase;
        m_we = 1'b0;
        if (m_phase == 2 || m_phase == 3) begin
            samples.push_back(m_s2);
            if (samples.size() > Deb) void'(samples.pop_front());
        end
        case (m_phase)
            0: begin
                if (bus.req_out) begin
                    nxt = 1;
                    if (bus.endereco < NRegs) begin
                        m_we = 1'b1; m_addr = bus.endereco[2:0]; m_wdata = bus.dadosEscrita;
                    end else begin
                        m_erro = 1'b1;
                    end
                end else if (bus.req_in) begin
                    nxt = 2;
                end
            end
            1: nxt = 0;
            2: begin
                if (!bus.req_in) nxt = 0;
                else if (held(1'b0)) begin
                    nxt = 3;
                    m_lidos = 32'($signed(bus.dadosExternos));
                end
            end
            3: if (held(1'b1)) nxt = 4;
            default: nxt = 0;
        endcase
        if (nxt != m_phase) samples.delete();
        m_phase = nxt;
        m_s2 = m_s1;
        m_s1 = bus.botao;
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic drive_idle();
        bus.req_in = 1'b0; bus.req_out = 1'b0; bus.endereco = '0; bus.dadosEscrita = '0;
        bus.dadosExternos = '0; bus.botao = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
        checks++; if (bus.io_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.io_we); end
        checks++; if (bus.io_addr !== 3'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", bus.io_addr); end
        checks++; if (bus.io_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.io_wdata); end
        checks++; if (bus.aguardando !== 1'b0) begin errors++; $display("FAIL rst_agu: got %b want 0", bus.aguardando); end
        checks++; if (bus.erro !== 1'b0) begin errors++; $display("FAIL rst_erro: got %b want 0", bus.erro); end
        checks++; if (bus.dadosLidos !== 32'd0) begin errors++; $display("FAIL rst_lidos: got %h want 0", bus.dadosLidos); end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_out_write();
        next_cycle();
        bus.req_out = 1'b1; bus.endereco = 32'd1; bus.dadosEscrita = 32'h0000_00AB;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL out_stall0: got %b want 1", bus.stall); end
        checks++; if (bus.io_we !== 1'b0) begin errors++; $display("FAIL out_we0: got %b want 0", bus.io_we); end
        next_cycle(); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL out_stall1: got %b want 0", bus.stall); end
        checks++; if (bus.io_we !== 1'b1) begin errors++; $display("FAIL out_we1: got %b want 1", bus.io_we); end
        checks++; if (bus.io_addr !== 3'd1) begin errors++; $display("FAIL out_addr: got %0d want 1", bus.io_addr); end
        checks++; if (bus.io_wdata !== 32'hAB) begin errors++; $display("FAIL out_wdata: got %h want ab", bus.io_wdata); end
        checks++; if (bus.erro !== 1'b0) begin errors++; $display("FAIL out_erro: got %b want 0", bus.erro); end
        next_cycle();
        bus.req_out = 1'b0;
        #1;
        checks++; if (bus.io_we !== 1'b0) begin errors++; $display("FAIL out_we2: got %b want 0", bus.io_we); end
    endtask

    task automatic test_out_invalid();
        logic [31:0] bad[2];
        bad[0] = 32'd7;
        bad[1] = 32'h8000_0001;
        foreach (bad[i]) begin
            next_cycle();
            bus.req_out = 1'b1; bus.endereco = bad[i]; bus.dadosEscrita = $urandom;
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL bad_stall0[%0d]: got %b want 1", i, bus.stall); end
            next_cycle(); #1;
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL bad_stall1[%0d]: got %b want 0", i, bus.stall); end
            checks++; if (bus.io_we !== 1'b0) begin errors++; $display("FAIL bad_we[%0d]: got %b want 0", i, bus.io_we); end
            checks++; if (bus.erro !== 1'b1) begin errors++; $display("FAIL bad_erro[%0d]: got %b want 1", i, bus.erro); end
        end
        // A following valid write does not clear the sticky error.
        next_cycle();
        bus.endereco = 32'd0; bus.dadosEscrita = 32'h55;
        next_cycle(); #1;
        checks++; if (bus.io_we !== 1'b1) begin errors++; $display("FAIL bad_valid_we: got %b want 1", bus.io_we); end
        checks++; if (bus.erro !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b want 1", bus.erro); end
        next_cycle();
        bus.req_out = 1'b0;
    endtask

    task automatic test_in_capture();
        int   done_k;
        logic agu_seen;
        done_k = -1; agu_seen = 1'b0;
        bus.dadosExternos = 18'h2_0005;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            bus.req_in = 1'b1;
            bus.botao  = (k < 6) ? 1'b0 : 1'b1;
            #1;
            if (k == 2) agu_seen = bus.aguardando;
            if (bus.stall == 1'b0) begin done_k = k; break; end
        end
        checks++; if (done_k != 12) begin errors++; $display("FAIL in_done_cycle: got %0d want 12", done_k); end
        checks++; if (agu_seen !== 1'b1) begin errors++; $display("FAIL in_agu: got %b want 1", agu_seen); end
        checks++; if (bus.dadosLidos !== 32'hFFFE_0005) begin errors++; $display("FAIL in_lidos: got %h want fffe0005", bus.dadosLidos); end
        next_cycle();
        bus.req_in = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL in_after_stall: got %b want 0", bus.stall); end
        checks++; if (bus.dadosLidos !== 32'hFFFE_0005) begin errors++; $display("FAIL in_hold: got %h want fffe0005", bus.dadosLidos); end
    endtask

    task automatic test_bounce();
        int fall_k, cap_k, done_k;
        fall_k = -1; cap_k = -1; done_k = -1;
        bus.dadosExternos = 18'h1_2345;
        for (int k = 0; k < 60; k++) begin
            next_cycle();
            bus.req_in = 1'b1;
            bus.botao  = (k < 4) ? k[0] : ((k < 12) ? 1'b0 : 1'b1);
            #1;
            if (k >= 1 && fall_k < 0 && bus.aguardando == 1'b0) fall_k = k;
            if (cap_k < 0 && bus.dadosLidos == 32'h0001_2345) cap_k = k;
            if (bus.stall == 1'b0) begin done_k = k; break; end
        end
        checks++; if (fall_k != 10) begin errors++; $display("FAIL bnc_press_exit: got %0d want 10", fall_k); end
        checks++; if (cap_k != 10) begin errors++; $display("FAIL bnc_capture: got %0d want 10", cap_k); end
        checks++; if (done_k != 18) begin errors++; $display("FAIL bnc_done: got %0d want 18", done_k); end
        next_cycle();
        bus.req_in = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] wd;
        wd = $urandom;
        next_cycle();
        bus.req_in = 1'b1; bus.req_out = 1'b1; bus.endereco = 32'd2; bus.dadosEscrita = wd;
        bus.botao = 1'b1; bus.dadosExternos = 18'h0_7777;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sim_stall0: got %b want 1", bus.stall); end
        next_cycle(); #1;
        checks++; if (bus.io_we !== 1'b1) begin errors++; $display("FAIL sim_we: got %b want 1", bus.io_we); end
        checks++; if (bus.io_wdata !== wd) begin errors++; $display("FAIL sim_wdata: got %h want %h", bus.io_wdata, wd); end
        checks++; if (bus.aguardando !== 1'b0) begin errors++; $display("FAIL sim_agu0: got %b want 0", bus.aguardando); end
        next_cycle();
        bus.req_out = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sim_stall2: got %b want 1", bus.stall); end
        next_cycle(); #1;
        checks++; if (bus.aguardando !== 1'b1) begin errors++; $display("FAIL sim_agu1: got %b want 1", bus.aguardando); end
        // Dropping the IN request while waiting abandons it without a capture.
        next_cycle();
        bus.req_in = 1'b0;
        next_cycle(); #1;
        checks++; if (bus.aguardando !== 1'b0) begin errors++; $display("FAIL sim_abort: got %b want 0", bus.aguardando); end
        checks++; if (bus.dadosLidos !== 32'h0001_2345) begin errors++; $display("FAIL sim_nocap: got %h want 00012345", bus.dadosLidos); end
    endtask

    task automatic test_reset_mid_press();
        logic agu;
        agu = 1'b0;
        bus.dadosExternos = 18'h3_FFFF;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.req_in = 1'b1; bus.botao = 1'b0;
            #1;
            agu = bus.aguardando;
        end
        checks++; if (agu !== 1'b1) begin errors++; $display("FAIL rmp_agu_before: got %b want 1", agu); end
        next_cycle();
        reset = 1'b1; bus.req_in = 1'b0; bus.botao = 1'b1;
        #1;
        checks++; if (bus.aguardando !== 1'b0) begin errors++; $display("FAIL rmp_agu: got %b want 0", bus.aguardando); end
        checks++; if (bus.erro !== 1'b0) begin errors++; $display("FAIL rmp_erro: got %b want 0", bus.erro); end
        checks++; if (bus.dadosLidos !== 32'd0) begin errors++; $display("FAIL rmp_lidos: got %h want 0", bus.dadosLidos); end
        checks++; if (bus.io_addr !== 3'd0) begin errors++; $display("FAIL rmp_addr: got %0d want 0", bus.io_addr); end
        next_cycle();
        reset = 1'b0;
        next_cycle(); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rmp_stall: got %b want 0", bus.stall); end
        checks++; if (bus.io_we !== 1'b0) begin errors++; $display("FAIL rmp_we: got %b want 0", bus.io_we); end
        checks++; if (bus.dadosLidos !== 32'd0) begin errors++; $display("FAIL rmp_lidos2: got %h want 0", bus.dadosLidos); end
    endtask

    task automatic test_random();
        int   kind, gap, errs_before;
        logic exp_stall, prev_done;
        kind = 0; gap = 0; prev_done = 1'b0; errs_before = errors;
        next_cycle();
        drive_idle();
        reset = 1'b1;
        model_reset();
        next_cycle();
        reset = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_cycle();
            if (prev_done) kind = 0;
            if (kind == 0) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    kind = int'($urandom_range(2, 1));
                    gap  = int'($urandom_range(2, 0));
                    bus.endereco = ($urandom_range(7, 0) == 0) ? 32'($urandom)
                                                               : 32'($urandom_range(7, 0));
                    bus.dadosEscrita = $urandom;
                end
            end else if (kind == 2 && $urandom_range(47, 0) == 0) begin
                kind = 0;
            end
            bus.req_out = (kind == 1);
            bus.req_in  = (kind == 2);
            bus.dadosExternos = 18'($urandom);
            if ($urandom_range(2, 0) == 0) bus.botao = ~bus.botao;
            #1;
            exp_stall = (bus.req_in || bus.req_out) && (m_phase == 0 || m_phase == 2 || m_phase == 3);
            checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", cyc, bus.stall, exp_stall); end
            checks++; if (bus.io_we !== m_we) begin errors++; $display("FAIL rnd_we@%0d: got %b want %b", cyc, bus.io_we, m_we); end
            if (m_we) begin
                checks++; if (bus.io_addr !== m_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %0d want %0d", cyc, bus.io_addr, m_addr); end
                checks++; if (bus.io_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata@%0d: got %h want %h", cyc, bus.io_wdata, m_wdata); end
            end
            checks++; if (bus.aguardando !== (m_phase == 2)) begin errors++; $display("FAIL rnd_agu@%0d: got %b want %b", cyc, bus.aguardando, (m_phase == 2)); end
            checks++; if (bus.erro !== m_erro) begin errors++; $display("FAIL rnd_erro@%0d: got %b want %b", cyc, bus.erro, m_erro); end
            checks++; if (bus.dadosLidos !== m_lidos) begin errors++; $display("FAIL rnd_lidos@%0d: got %h want %h", cyc, bus.dadosLidos, m_lidos); end
            prev_done = (bus.req_in || bus.req_out) && !exp_stall;
            model_step();
            if (errors - errs_before > 20) break;
        end
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_out_invalid();
        test_in_capture();
        test_bounce();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
